shift_adder_pipe: RTL

//  Pipelined, handshaked two-operand shift-adder: out = in0 +/- (in1 << SHIFT1), op chosen per beat.

---
 rtl/shift_adder_pipe.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/shift_adder_pipe.sv
// -----------------------------------------------------------------------------
// shift_adder_pipe
//   Pipelined, valid/ready handshaked shift-adder.
//     SHIFT1 >= 0 : result = in0_ext +/- (in1_ext << SHIFT1)
//     SHIFT1 <  0 : result = (in0_ext << -SHIFT1) +/- in1_ext
//   The add/sub choice travels with each beat (in_sub). The internal adder is
//   BW_ADD bits wide and never overflows. out is the low BW_OUT bits of the
//   exact result (wrap), or the result clamped to the BW_OUT range when the
//   macro SHIFT_ADDER_SAT_EN is defined.
//
// Ports
//   clk        clock, all state on rising edge
//   rst_n      synchronous reset, active low (clears valids and data)
//   in_valid   input beat valid
//   in_ready   block can accept a beat (stage-0 load enable, 0 in reset)
//   in0, in1   operands (signedness set by SIGNED0 / SIGNED1)
//   in_sub     1: subtract, 0: add
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   out        result, BW_OUT bits, registered
//   out_sat    result was clamped (always 0 without SHIFT_ADDER_SAT_EN)
//
// Pipeline (PIPE_STAGES = 1..4)
//   stage 0    extended operands + op    (PIPE_STAGES >= 2)
//   stage 1    BW_ADD sum / difference   (stage 0 holds it when PIPE_STAGES = 1)
//   stage 2..  plain delay
//   last stage holds the formatted (wrapped or clamped) output.
// -----------------------------------------------------------------------------
module shift_adder_pipe #(
    parameter int BW_INPUT0   = 16,
    parameter int BW_INPUT1   = 16,
    parameter int SIGNED0     = 1,
    parameter int SIGNED1     = 1,
    parameter int BW_OUT      = 32,
    parameter int OUT_SIGNED  = 1,
    parameter int SHIFT1      = 0,
    parameter int PIPE_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BW_INPUT0-1:0] in0,
    input  logic [BW_INPUT1-1:0] in1,
    input  logic                 in_sub,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BW_OUT-1:0]    out,
    output logic                 out_sat
);

    localparam int SH0    = (SHIFT1 < 0) ? -SHIFT1 : 0;
    localparam int SH1    = (SHIFT1 > 0) ? SHIFT1 : 0;
    localparam int NEED0  = BW_INPUT0 + SH0;
    localparam int NEED1  = BW_INPUT1 + SH1;
    localparam int BW_ADD = ((NEED0 > NEED1) ? NEED0 : NEED1) + 2 + ((SIGNED0 != SIGNED1) ? 1 : 0);
    // one bit wider than both the adder and the output so every bound fits
    localparam int BW_W   = ((BW_ADD > BW_OUT) ? BW_ADD : BW_OUT) + 1;

`ifdef SHIFT_ADDER_SAT_EN
    // Clamp the exact result to the output range; MSB of return = clamped flag.
    function automatic logic [BW_OUT:0] format_fn(input logic signed [BW_ADD-1:0] v);
        logic signed [BW_W-1:0] w_s;
        logic signed [BW_W-1:0] hi_s;
        logic [BW_OUT:0]        r_s;
        w_s = {{(BW_W-BW_ADD){v[BW_ADD-1]}}, v};
        if (OUT_SIGNED != 0) begin
            // in range iff everything above the output sign bit is a sign copy
            hi_s = w_s >>> (BW_OUT - 1);
            if ((hi_s == '0) || (hi_s == '1)) begin
                r_s = {1'b0, w_s[BW_OUT-1:0]};
            end else if (w_s[BW_W-1]) begin
                r_s = {1'b1, 1'b1, {(BW_OUT-1){1'b0}}};
            end else begin
                r_s = {1'b1, 1'b0, {(BW_OUT-1){1'b1}}};
            end
        end else begin
            hi_s = w_s >>> BW_OUT;
            if (hi_s == '0) begin
                r_s = {1'b0, w_s[BW_OUT-1:0]};
            end else if (w_s[BW_W-1]) begin
                r_s = {1'b1, {BW_OUT{1'b0}}};
            end else begin
                r_s = {1'b1, {BW_OUT{1'b1}}};
            end
        end
        return r_s;
    endfunction
`else
    // Wrap: low BW_OUT bits of the sign-extended exact result; flag is always 0.
    function automatic logic [BW_OUT:0] format_fn(input logic signed [BW_ADD-1:0] v);
        return {1'b0, BW_OUT'({{(BW_W-BW_ADD){v[BW_ADD-1]}}, v})};
    endfunction
`endif

    logic [PIPE_STAGES-1:0]    valid_r;
    logic [PIPE_STAGES-1:0]    load_s;
    logic [PIPE_STAGES-1:0]    prev_valid_s;
    logic [PIPE_STAGES-1:0]    full_mask_s;
    logic signed [BW_ADD-1:0]  a_ext_s;
    logic signed [BW_ADD-1:0]  b_ext_s;
    logic signed [BW_ADD-1:0]  sum_a_s;
    logic signed [BW_ADD-1:0]  sum_b_s;
    logic                      sum_sub_s;
    logic signed [BW_ADD-1:0]  sum_s;
    logic signed [BW_ADD-1:0]  last_in_s;
    logic [BW_OUT:0]           fmt_s;

    // Extend to BW_ADD (sign or zero), then zero-fill the shifted operand.
    assign a_ext_s = {{(BW_ADD-BW_INPUT0){(SIGNED0 != 0) & in0[BW_INPUT0-1]}}, in0} << SH0;
    assign b_ext_s = {{(BW_ADD-BW_INPUT1){(SIGNED1 != 0) & in1[BW_INPUT1-1]}}, in1} << SH1;

    // Stage k loads when any stage from k to the last is empty, or output drains.
    // Written without a chained self-reference so there is no combinational loop.
    always_comb begin
        load_s      = '0;
        full_mask_s = '0;
        for (int k = 0; k < PIPE_STAGES; k++) begin
            full_mask_s = {PIPE_STAGES{1'b1}} << k;
            load_s[k]   = out_ready | ((valid_r & full_mask_s) != full_mask_s);
        end
    end

    // Valid feeding each stage: in_valid for stage 0, previous stage otherwise.
    always_comb begin
        prev_valid_s    = '0;
        prev_valid_s[0] = in_valid;
        for (int k = 1; k < PIPE_STAGES; k++) begin
            prev_valid_s[k] = valid_r[k-1];
        end
    end

    assign in_ready  = rst_n & load_s[0];
    assign out_valid = valid_r[PIPE_STAGES-1];

    // Per-stage valid bits; a loading stage takes its predecessor's valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_r <= '0;
        end else begin
            for (int k = 0; k < PIPE_STAGES; k++) begin
                if (load_s[k]) begin
                    valid_r[k] <= prev_valid_s[k];
                end
            end
        end
    end

    // Full-width exact sum or difference.
    always_comb begin
        if (sum_sub_s) begin
            sum_s = sum_a_s - sum_b_s;
        end else begin
            sum_s = sum_a_s + sum_b_s;
        end
    end

    generate
        if (PIPE_STAGES == 1) begin : g_p1
            // Single stage: the adder works straight from the inputs.
            always_comb begin
                sum_a_s   = a_ext_s;
                sum_b_s   = b_ext_s;
                sum_sub_s = in_sub;
            end
            assign last_in_s = sum_s;
        end else begin : g_pn
            logic signed [BW_ADD-1:0] op_a_r;
            logic signed [BW_ADD-1:0] op_b_r;
            logic                     op_sub_r;

            // Stage 0: extended operands and op, loaded only with a real beat.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    op_a_r   <= '0;
                    op_b_r   <= '0;
                    op_sub_r <= 1'b0;
                end else if (load_s[0] && in_valid) begin
                    op_a_r   <= a_ext_s;
                    op_b_r   <= b_ext_s;
                    op_sub_r <= in_sub;
                end
            end

            assign sum_a_s   = op_a_r;
            assign sum_b_s   = op_b_r;
            assign sum_sub_s = op_sub_r;

            if (PIPE_STAGES == 2) begin : g_p2
                assign last_in_s = sum_s;
            end else begin : g_p34
                logic signed [BW_ADD-1:0] mid_r [1:PIPE_STAGES-2];

                // Stage 1 holds the sum, later middle stages only delay it.
                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        for (int k = 1; k <= PIPE_STAGES-2; k++) begin
                            mid_r[k] <= '0;
                        end
                    end else begin
                        if (load_s[1] && valid_r[0]) begin
                            mid_r[1] <= sum_s;
                        end
                        for (int k = 2; k <= PIPE_STAGES-2; k++) begin
                            if (load_s[k] && valid_r[k-1]) begin
                                mid_r[k] <= mid_r[k-1];
                            end
                        end
                    end
                end

                assign last_in_s = mid_r[PIPE_STAGES-2];
            end
        end
    endgenerate

    assign fmt_s = format_fn(last_in_s);

    // Last stage: formatted result; held while stalled or when no beat arrives.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out     <= '0;
            out_sat <= 1'b0;
        end else if (load_s[PIPE_STAGES-1] && prev_valid_s[PIPE_STAGES-1]) begin
            out     <= fmt_s[BW_OUT-1:0];
            out_sat <= fmt_s[BW_OUT];
        end
    end

endmodule
